audio_i2s_tx: RTL
=================

# audio_i2s_tx

Single-clock I2S audio transmitter that replaces the silence generator in the core top level. It accepts 16-bit stereo samples from the CPU-side audio register through a valid/ready handshake and buffers them in a 4-entry FIFO. It derives MCLK (12.288 MHz) and SCLK (3.072 MHz) from `clk_74a` using clock enables, and serializes one 48 kHz I2S frame of 64 SCLK slots per sample pair onto `audio_dac`/`audio_lrck`.

## Interface
Parameters:
- `INC`, default 245760: fractional accumulator increment; this is 2 × 122880.
- `MOD`, default 742500: fractional accumulator modulus.
- `DEPTH`, default 4: sample FIFO depth. It must be a power of two.

Ports:
- `clk`  in  1  — 74.25 MHz clock (`clk_74a`). This is the only clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `i_sample_valid`  in  1  — sample offered.
- `i_sample_data`  in  32  — `{left[15:0], right[15:0]}`, two's complement.
- `o_sample_ready`  out  1  — FIFO not full.
- `o_fifo_level`  out  3  — number of entries held, 0..4.
- `o_underflow`  out  1  — one-cycle pulse when a frame starts with the FIFO empty.
- `audio_mclk`  out  1  — 12.288 MHz master clock, registered.
- `audio_sclk`  out  1  — bit clock, equal to MCLK/4, registered.
- `audio_lrck`  out  1  — word select; 0 = left.
- `audio_dac`  out  1  — serial data, MSB first.

## Operation
- **Accumulator (22 bit, reset 0):**
  - Each `clk` cycle, `acc <= acc + INC`.
  - If `acc >= MOD`, instead `acc <= acc - MOD + INC` and toggle `audio_mclk`.
  - Over any 742500 clocks this yields exactly 122880 MCLK periods.
- **MCLK rise event:** a toggle where `audio_mclk` goes 0→1.
  - On this event, `div[1:0]` increments.
  - `audio_sclk = div[1]`, registered.
- **SCLK fall event (`sfall`):** an MCLK rise event where `div == 3`.
- **Slot counter `cnt[5:0]`:** reset value 63. It increments by 1 on each `sfall` and wraps 63→0.
- **Sample fetch:** on the `sfall` that produces `cnt == 0`:
  - If the FIFO is non-empty, pop the head into `frame_reg`.
  - Otherwise load `frame_reg <= 0` and pulse `o_underflow`.
- **Outputs on every `sfall`, where `s` is the new `cnt`:**
  - `audio_lrck <= s[5]`.
  - `audio_dac`:
    - for s = 1..16: `left[16-s]`;
    - for s = 33..48: `right[48-s]`;
    - for all other slots, including s = 0 and s = 32: 0.
  - This gives the standard I2S one-slot MSB delay after each LRCK edge.
  - `audio_dac` uses the `frame_reg` value that is valid after that same edge's fetch. The fetch on s = 0 is visible from s = 1 onward.
- **FIFO:**
  - Push when `i_sample_valid && o_sample_ready`.
  - `o_sample_ready = (level != DEPTH)`.
  - A push and a pop in the same cycle are both performed and leave the level unchanged.
  - When the FIFO is full, a push is not accepted. Data is never overwritten.
  - A pop on an empty FIFO never happens; that case is the underflow path above.
- **Reset values:**
  - `audio_mclk`, `audio_sclk`, `audio_dac`, `o_underflow`: 0.
  - `audio_lrck`: 1.
  - `o_fifo_level`: 0.
  - `o_sample_ready`: 1.
- Asserting reset mid-frame aborts the frame immediately. The FIFO is flushed and the first frame after release starts at s = 0.

## Timing
- All outputs are registered in the `clk` domain and change only on `clk` edges.
- MCLK toggles are at most one per clock. Their spacing is 3 or 4 clocks (74.25/24.576 ≈ 3.02).
- `sfall` occurs once every 8 MCLK toggles, averaging 24.17 clocks.
- Frame length is 64 `sfall`s, averaging 1546.875 clocks, giving exactly 48 kHz on average.
- **Accept → output latency:**
  - A sample pushed into an empty FIFO before the `cnt == 0` `sfall` has its left MSB driven on the next `sfall` after that one.
  - Otherwise it waits for subsequent frames in FIFO order.
- `o_underflow` is high for exactly one `clk` cycle, on the same edge as the `cnt == 0` update.
- `o_fifo_level` and `o_sample_ready` update on the clock after the push/pop edge.

## Structure
- **Package `audio_i2s_pkg`:**
  - `INC`/`MOD` defaults;
  - `SLOTS_PER_FRAME = 64`;
  - `SAMPLE_W = 16`;
  - left/right slot bounds 1..16 and 33..48.
- **Sub-module `audio_sample_fifo`:**
  - synchronous FIFO with parameterized `DEPTH`;
  - async active-low reset;
  - push/pop/level interface;
  - registered read data at the head.
- **Top `audio_i2s_tx`:** contains the accumulator, divider, slot counter, frame register and serializer.

## Test plan
- **Clock generation:** reset, then run 742500 clocks → exactly 122880 MCLK rising edges, 30720 SCLK periods and 480 full LRCK periods (±1 for the phase at the window edge).
- **Single sample:** push `0xA5C3_3C5A` into an empty FIFO, then capture bits on SCLK rising edges.
  - left = 0xA5C3, appearing 1 slot after LRCK falls;
  - right = 0x3C5A, appearing 1 slot after LRCK rises;
  - the padding slots are 0.
- **Backpressure:** hold `i_sample_valid` high with values 1..6 and no frame boundary.
  - Exactly 4 are accepted.
  - `o_sample_ready` = 0 and `o_fifo_level` = 4.
  - The next frames output 1, 2, 3, 4 in order.
- **Underflow:** let the FIFO run empty.
  - `o_underflow` pulses once per frame, for 1 cycle.
  - `audio_dac` stays 0 for the whole frame.
  - A later push resumes output at the next frame.
- **Simultaneous push/pop:** push at level 2 on the same clock as the `cnt == 0` pop → level stays 2 and no sample is lost or duplicated.
- **Mid-frame reset:** assert `reset_n` = 0 at slot 20 with 3 samples queued.
  - All outputs take their reset values asynchronously, and the level goes to 0.
  - After release, the first frame outputs zeros and pulses `o_underflow`.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// Shared constants and slot-to-bit mapping for the I2S transmitter.
// A frame is 64 SCLK slots; each word is sent MSB first, one slot after the LRCK edge.
package audio_i2s_pkg;

   localparam int INC_DEFAULT     = 245760;
   localparam int MOD_DEFAULT     = 742500;
   localparam int ACC_W           = 22;
   localparam int SLOTS_PER_FRAME = 64;
   localparam int SLOT_W          = 6;
   localparam int SAMPLE_W        = 16;
   localparam int FRAME_W         = 2 * SAMPLE_W;

   localparam logic [SLOT_W-1:0] LEFT_FIRST  = 6'd1;
   localparam logic [SLOT_W-1:0] LEFT_LAST   = 6'd16;
   localparam logic [SLOT_W-1:0] RIGHT_FIRST = 6'd33;
   localparam logic [SLOT_W-1:0] RIGHT_LAST  = 6'd48;
   localparam logic [SLOT_W-1:0] LEFT_BASE   = 6'd32;
   localparam logic [SLOT_W-1:0] RIGHT_BASE  = 6'd48;

   typedef enum logic [1:0] {
      SLOT_PAD,
      SLOT_LEFT,
      SLOT_RIGHT
   } slot_kind_e;

   function automatic slot_kind_e slot_kind(input logic [SLOT_W-1:0] s);
      slot_kind_e k;
      k = SLOT_PAD;
      if (s >= LEFT_FIRST && s <= LEFT_LAST) begin
         k = SLOT_LEFT;
      end else if (s >= RIGHT_FIRST && s <= RIGHT_LAST) begin
         k = SLOT_RIGHT;
      end
      return k;
   endfunction

   // Frame packing is {left, right}: left[16-s] sits at frame[32-s], right[48-s] at frame[48-s].
   function automatic logic slot_bit(input logic [FRAME_W-1:0] frame,
                                     input logic [SLOT_W-1:0]  s);
      logic bit_v;
      bit_v = 1'b0;
      case (slot_kind(s))
         SLOT_LEFT:  bit_v = frame[5'(LEFT_BASE - s)];
         SLOT_RIGHT: bit_v = frame[5'(RIGHT_BASE - s)];
         default:    bit_v = 1'b0;
      endcase
      return bit_v;
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample FIFO with a registered head word and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module audio_sample_fifo
   import audio_i2s_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = FRAME_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [AW:0]   level_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW + 1)'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   level_q, level_d;
   logic [W-1:0]  head_q, head_d;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = head_q;

   always_comb begin
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop_ok);
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + ONE_LVL;
         2'b01:   level_d = level_q - ONE_LVL;
         default: level_d = level_q;
      endcase
      // When the write slot becomes the head, forward the incoming word directly.
      if (push_ok && (wr_q == rd_d)) begin
         head_d = data_i;
      end else begin
         head_d = mem_q[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         head_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         head_q  <= head_d;
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: fractional MCLK/SCLK generation from the system clock, a 64-slot
// frame counter, and serialization of FIFO-buffered stereo samples.
module audio_i2s_tx
   import audio_i2s_pkg::*;
#(
   parameter int INC   = INC_DEFAULT,
   parameter int MOD   = MOD_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_sample_valid,
   input  logic [FRAME_W-1:0]       i_sample_data,
   output logic                     o_sample_ready,
   output logic [$clog2(DEPTH):0]   o_fifo_level,
   output logic                     o_underflow,
   output logic                     audio_mclk,
   output logic                     audio_sclk,
   output logic                     audio_lrck,
   output logic                     audio_dac
);

   localparam logic [ACC_W-1:0]  INC_W     = ACC_W'(INC);
   localparam logic [ACC_W-1:0]  MOD_W     = ACC_W'(MOD);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);
   localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               mclk_q, mclk_d;
   logic [1:0]         div_q, div_d;
   logic               sclk_q;
   logic [SLOT_W-1:0]  cnt_q, cnt_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               lrck_q, lrck_d;
   logic               dac_q, dac_d;
   logic               unf_q, unf_d;
   logic               mtog, mrise, sfall, fetch;
   logic               fifo_pop, fifo_empty, fifo_full;
   logic [FRAME_W-1:0] fifo_head;

   audio_sample_fifo #(
      .DEPTH (DEPTH),
      .W     (FRAME_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (i_sample_valid),
      .data_i  (i_sample_data),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .level_o (o_fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      // Accumulator overflow marks an MCLK half-period; INC/MOD sets the exact long-run rate.
      mtog     = (acc_q >= MOD_W);
      acc_d    = mtog ? (acc_q - MOD_W + INC_W) : (acc_q + INC_W);
      mclk_d   = mclk_q ^ mtog;
      mrise    = mtog && !mclk_q;
      div_d    = mrise ? (div_q + 2'd1) : div_q;
      sfall    = mrise && (div_q == 2'd3);
      fetch    = sfall && (cnt_q == LAST_SLOT);
      fifo_pop = fetch && !fifo_empty;
      unf_d    = fetch && fifo_empty;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      lrck_d   = lrck_q;
      dac_d    = dac_q;
      if (sfall) begin
         cnt_d = cnt_q + ONE_SLOT;
         if (fetch) begin
            frame_d = fifo_empty ? '0 : fifo_head;
         end
         lrck_d = cnt_d[SLOT_W-1];
         dac_d  = slot_bit(frame_d, cnt_d);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         mclk_q  <= 1'b0;
         div_q   <= '0;
         sclk_q  <= 1'b0;
         cnt_q   <= LAST_SLOT;
         frame_q <= '0;
         lrck_q  <= 1'b1;
         dac_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         mclk_q  <= mclk_d;
         div_q   <= div_d;
         sclk_q  <= div_d[1];
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         lrck_q  <= lrck_d;
         dac_q   <= dac_d;
         unf_q   <= unf_d;
      end
   end

   assign o_sample_ready = !fifo_full;
   assign o_underflow    = unf_q;
   assign audio_mclk     = mclk_q;
   assign audio_sclk     = sclk_q;
   assign audio_lrck     = lrck_q;
   assign audio_dac      = dac_q;

endmodule
